// File: rtl/axi_ram_slave_pkg.sv
// Shared AXI constants and channel FSM state encodings for the RAM responder.
package axi_ram_slave_pkg;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BEAT} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
endpackage

// File: rtl/axi_ram_bytewe.sv
// Single-clock 1R1W word RAM, byte write enables, registered read port.
module axi_ram_bytewe import axi_ram_slave_pkg::*; #(
    parameter int    DEPTH     = 4096,
    parameter int    AW        = 12,
    parameter string INIT_FILE = ""
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata
);
    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++)
            if (i_we[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
    end

    // Output register only moves on a load, so it doubles as the held R beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  o_rdata <= '0;
        else if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/axi_ram_slave.sv
// AXI4 INCR burst responder over word RAM; one read and one write burst in flight.
module axi_ram_slave import axi_ram_slave_pkg::*; #(
    parameter int    DEPTH_WORDS = 4096,
    parameter int    RD_LATENCY  = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  ar_id,
    input  logic [31:0] ar_addr,
    input  logic [7:0]  ar_len,
    input  logic        ar_valid,
    output logic        ar_ready,
    output logic [3:0]  r_id,
    output logic [31:0] r_data,
    output logic        r_last,
    output logic        r_valid,
    input  logic        r_ready,
    input  logic [31:0] aw_addr,
    input  logic [7:0]  aw_len,
    input  logic        aw_valid,
    output logic        aw_ready,
    input  logic [31:0] w_data,
    input  logic [3:0]  w_strb,
    input  logic        w_last,
    input  logic        w_valid,
    output logic        w_ready,
    output logic [1:0]  b_resp,
    output logic        b_valid,
    input  logic        b_ready
);
    localparam int            AW       = $clog2(DEPTH_WORDS);
    localparam int            LW       = $clog2(RD_LATENCY + 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(RD_LATENCY > 1 ? RD_LATENCY - 2 : 0);
    localparam logic [LW-1:0] ONE_L    = 1;
    localparam logic [AW-1:0] ONE_W    = 1;
    localparam bit            DIRECT   = (RD_LATENCY == 1);

    rd_state_e     r_rstate;
    logic [3:0]    r_rid;
    logic [AW-1:0] r_ridx;
    logic [7:0]    r_rlen, r_rcnt;
    logic [LW-1:0] r_lat;
    logic          r_rvalid, r_rlast;

    wr_state_e     r_wstate;
    logic [AW-1:0] r_widx;
    logic [7:0]    r_wlen;
    logic [8:0]    r_wcnt;
    logic          r_werr;
    logic [1:0]    r_bresp;

    logic          w_re;
    logic [AW-1:0] w_raddr;
    logic          w_in_len, w_cnt_eq, w_wr;
    logic [3:0]    w_we;
    logic          w_unused;

    assign w_unused = ^{ar_addr[31:AW+2], ar_addr[1:0], aw_addr[31:AW+2], aw_addr[1:0]};

    // RAM load happens on the edge that enters R_BEAT; with unit latency the
    // address comes straight from AR or the next index so beats run back-to-back.
    always_comb begin
        w_re    = 1'b0;
        w_raddr = r_ridx;
        case (r_rstate)
            R_IDLE: if (ar_valid && DIRECT) begin
                w_re    = 1'b1;
                w_raddr = ar_addr[2 +: AW];
            end
            R_WAIT: w_re = (r_lat == LAT_LAST);
            R_BEAT: if (r_ready && !r_rlast && DIRECT) begin
                w_re    = 1'b1;
                w_raddr = r_ridx + ONE_W;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rstate <= R_IDLE;
            r_rid    <= '0;
            r_ridx   <= '0;
            r_rlen   <= '0;
            r_rcnt   <= '0;
            r_lat    <= '0;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: if (ar_valid) begin
                    r_rid  <= ar_id;
                    r_ridx <= ar_addr[2 +: AW];
                    r_rlen <= ar_len;
                    r_rcnt <= '0;
                    r_lat  <= '0;
                    if (DIRECT) begin
                        r_rstate <= R_BEAT;
                        r_rvalid <= 1'b1;
                        r_rlast  <= (ar_len == 8'd0);
                    end else begin
                        r_rstate <= R_WAIT;
                    end
                end
                R_WAIT: if (r_lat == LAT_LAST) begin
                    r_rstate <= R_BEAT;
                    r_rvalid <= 1'b1;
                    r_rlast  <= (r_rcnt == r_rlen);
                end else begin
                    r_lat <= r_lat + ONE_L;
                end
                R_BEAT: if (r_ready) begin
                    if (r_rlast) begin
                        r_rstate <= R_IDLE;
                        r_rvalid <= 1'b0;
                        r_rlast  <= 1'b0;
                    end else begin
                        r_ridx <= r_ridx + ONE_W;
                        r_rcnt <= r_rcnt + 8'd1;
                        r_lat  <= '0;
                        if (DIRECT) begin
                            r_rlast <= (r_rcnt + 8'd1 == r_rlen);
                        end else begin
                            r_rstate <= R_WAIT;
                            r_rvalid <= 1'b0;
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // Beats past len are swallowed so the master still sees a response at w_last.
    assign w_in_len = (r_wcnt <= {1'b0, r_wlen});
    assign w_cnt_eq = (r_wcnt == {1'b0, r_wlen});
    assign w_wr     = (r_wstate == W_DATA) && w_valid && w_in_len;
    assign w_we     = w_wr ? w_strb : 4'b0000;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wstate <= W_IDLE;
            r_widx   <= '0;
            r_wlen   <= '0;
            r_wcnt   <= '0;
            r_werr   <= 1'b0;
            r_bresp  <= AXI_RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: if (aw_valid) begin
                    r_wstate <= W_DATA;
                    r_widx   <= aw_addr[2 +: AW];
                    r_wlen   <= aw_len;
                    r_wcnt   <= '0;
                    r_werr   <= 1'b0;
                end
                W_DATA: if (w_valid) begin
                    if (w_in_len) begin
                        r_widx <= r_widx + ONE_W;
                        r_wcnt <= r_wcnt + 9'd1;
                    end
                    if (w_last) begin
                        r_wstate <= W_RESP;
                        r_bresp  <= (r_werr || !w_cnt_eq) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    end else if (w_cnt_eq) begin
                        r_werr <= 1'b1;
                    end
                end
                W_RESP: if (b_ready) r_wstate <= W_IDLE;
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    axi_ram_bytewe #(.DEPTH(DEPTH_WORDS), .AW(AW), .INIT_FILE(INIT_FILE)) u_ram (
        .i_clk   (aclk),
        .i_rst_n (aresetn),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (r_data),
        .i_we    (w_we),
        .i_waddr (r_widx),
        .i_wdata (w_data)
    );

    assign ar_ready = (r_rstate == R_IDLE);
    assign r_valid  = r_rvalid;
    assign r_last   = r_rlast;
    assign r_id     = r_rid;
    assign aw_ready = (r_wstate == W_IDLE);
    assign w_ready  = (r_wstate == W_DATA);
    assign b_valid  = (r_wstate == W_RESP);
    assign b_resp   = r_bresp;
endmodule

// File: tb/tb_axi_ram_slave.sv
// Bench for axi_ram_slave: two instances (read latency 1 and 3) share stimulus
// and are checked every cycle against a transaction-level memory/channel model.
module tb_axi_ram_slave;
    localparam int DEPTH = 4096;

    logic aclk = 1'b0;
    logic aresetn = 1'b1;
    always #5 aclk = ~aclk;

    logic [3:0]  ar_id;
    logic [31:0] ar_addr, aw_addr, w_data;
    logic [7:0]  ar_len, aw_len;
    logic        ar_valid, r_ready, aw_valid, w_last, w_valid, b_ready;
    logic [3:0]  w_strb;

    logic [1:0]       ar_ready, r_last, r_valid, aw_ready, w_ready, b_valid;
    logic [1:0][3:0]  r_id;
    logic [1:0][31:0] r_data;
    logic [1:0][1:0]  b_resp;

    axi_ram_slave #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(1), .INIT_FILE("")) u_dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_valid(ar_valid), .ar_ready(ar_ready[0]),
        .r_id(r_id[0]), .r_data(r_data[0]), .r_last(r_last[0]), .r_valid(r_valid[0]), .r_ready(r_ready),
        .aw_addr(aw_addr), .aw_len(aw_len), .aw_valid(aw_valid), .aw_ready(aw_ready[0]),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready[0]),
        .b_resp(b_resp[0]), .b_valid(b_valid[0]), .b_ready(b_ready)
    );

    axi_ram_slave #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(3), .INIT_FILE("")) u_dut3 (
        .aclk(aclk), .aresetn(aresetn),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_valid(ar_valid), .ar_ready(ar_ready[1]),
        .r_id(r_id[1]), .r_data(r_data[1]), .r_last(r_last[1]), .r_valid(r_valid[1]), .r_ready(r_ready),
        .aw_addr(aw_addr), .aw_len(aw_len), .aw_valid(aw_valid), .aw_ready(aw_ready[1]),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready[1]),
        .b_resp(b_resp[1]), .b_valid(b_valid[1]), .b_ready(b_ready)
    );

    int n_chk = 0;
    int n_fail = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Model: memory image, per-instance read burst progress, write channel phase.
    logic [31:0] m_mem  [DEPTH];
    logic [31:0] m_snap [2][256];
    logic        m_rbusy [2];
    int          m_rdly [2], m_rbeat [2], m_rlen [2];
    logic [3:0]  m_rid [2];
    int          m_wph, m_widx, m_wlen, m_wcnt;
    logic        m_werr;
    logic [1:0]  m_bresp;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < 2; i++) begin
                m_rbusy[i] <= 1'b0;
                m_rdly[i]  <= 0;
                m_rbeat[i] <= 0;
                m_rlen[i]  <= 0;
                m_rid[i]   <= 4'd0;
            end
            m_wph   <= 0;
            m_wcnt  <= 0;
            m_werr  <= 1'b0;
            m_bresp <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!m_rbusy[i]) begin
                    if (ar_valid) begin
                        m_rbusy[i] <= 1'b1;
                        m_rid[i]   <= ar_id;
                        m_rlen[i]  <= int'(ar_len);
                        m_rbeat[i] <= 0;
                        m_rdly[i]  <= lat(i) - 1;
                        for (int k = 0; k <= int'(ar_len); k++)
                            m_snap[i][k] <= m_mem[(int'(ar_addr[31:2]) + k) % DEPTH];
                    end
                end else if (m_rdly[i] == 0) begin
                    if (r_ready) begin
                        if (m_rbeat[i] == m_rlen[i]) m_rbusy[i] <= 1'b0;
                        else begin
                            m_rbeat[i] <= m_rbeat[i] + 1;
                            m_rdly[i]  <= lat(i) - 1;
                        end
                    end
                end else begin
                    m_rdly[i] <= m_rdly[i] - 1;
                end
            end
            case (m_wph)
                0: if (aw_valid) begin
                    m_wph  <= 1;
                    m_widx <= int'(aw_addr[31:2]) % DEPTH;
                    m_wlen <= int'(aw_len);
                    m_wcnt <= 0;
                    m_werr <= 1'b0;
                end
                1: if (w_valid) begin
                    if (m_wcnt <= m_wlen) begin
                        for (int b = 0; b < 4; b++)
                            if (w_strb[b]) m_mem[m_widx][8*b +: 8] <= w_data[8*b +: 8];
                        m_widx <= (m_widx + 1) % DEPTH;
                        m_wcnt <= m_wcnt + 1;
                    end
                    if (w_last) begin
                        m_wph   <= 2;
                        m_bresp <= (m_werr || m_wcnt != m_wlen) ? 2'b10 : 2'b00;
                    end else if (m_wcnt == m_wlen) begin
                        m_werr <= 1'b1;
                    end
                end
                default: if (b_ready) m_wph <= 0;
            endcase
        end
    end

    always @(negedge aclk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d ar_ready", i), ar_ready[i], !m_rbusy[i]);
            chk($sformatf("u%0d r_valid", i), r_valid[i], m_rbusy[i] && m_rdly[i] == 0);
            if (m_rbusy[i] && m_rdly[i] == 0) begin
                chk($sformatf("u%0d r_data beat%0d", i, m_rbeat[i]), r_data[i], m_snap[i][m_rbeat[i]]);
                chk($sformatf("u%0d r_id", i), r_id[i], m_rid[i]);
                chk($sformatf("u%0d r_last beat%0d", i, m_rbeat[i]), r_last[i], m_rbeat[i] == m_rlen[i]);
            end
            chk($sformatf("u%0d aw_ready", i), aw_ready[i], m_wph == 0);
            chk($sformatf("u%0d w_ready", i), w_ready[i], m_wph == 1);
            chk($sformatf("u%0d b_valid", i), b_valid[i], m_wph == 2);
            if (m_wph == 2) chk($sformatf("u%0d b_resp", i), b_resp[i], m_bresp);
        end
    end

    // Capture of accepted beats and responses for literal expectations.
    logic [31:0] rq0 [$];
    logic [31:0] rq1 [$];
    logic [1:0]  last_bresp = 2'b11;
    always @(posedge aclk) begin
        if (r_valid[0] && r_ready) rq0.push_back(r_data[0]);
        if (r_valid[1] && r_ready) rq1.push_back(r_data[1]);
        if (b_valid[0] && b_ready) last_bresp <= b_resp[0];
    end

    logic [31:0] wdat [16];

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_idle(input bit rd_only, input bit tog);
        int n = 0;
        while (!(&ar_ready && (rd_only || &aw_ready)) && n < 500) begin
            if (tog) r_ready = ~r_ready;
            tick();
            n++;
        end
        if (n >= 500) begin
            n_chk++;
            n_fail++;
            $display("FAIL idle timeout: got busy expected idle at %0t", $time);
        end
    endtask

    task automatic rd(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input bit tog);
        wait_idle(1'b0, 1'b0);
        rq0.delete();
        rq1.delete();
        ar_id = id; ar_addr = a; ar_len = len; ar_valid = 1'b1;
        tick();
        ar_valid = 1'b0;
        wait_idle(1'b1, tog);
        r_ready = 1'b1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] len, input int nb, input logic [3:0] strb);
        wait_idle(1'b0, 1'b0);
        aw_addr = a; aw_len = len; aw_valid = 1'b1;
        tick();
        aw_valid = 1'b0;
        for (int b = 0; b < nb; b++) begin
            w_valid = 1'b1; w_data = wdat[b]; w_strb = strb; w_last = (b == nb - 1);
            tick();
        end
        w_valid = 1'b0; w_last = 1'b0;
        wait_idle(1'b0, 1'b0);
    endtask

    initial begin
        ar_id = 0; ar_addr = 0; ar_len = 0; ar_valid = 0; r_ready = 1;
        aw_addr = 0; aw_len = 0; aw_valid = 0;
        w_data = 0; w_strb = 0; w_last = 0; w_valid = 0; b_ready = 1;
        #1 aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        for (int i = 0; i < 2; i++) begin
            chk("reset ar_ready", ar_ready[i], 1);
            chk("reset aw_ready", aw_ready[i], 1);
            chk("reset r_valid", r_valid[i], 0);
            chk("reset w_ready", w_ready[i], 0);
            chk("reset b_valid", b_valid[i], 0);
            chk("reset r_last", r_last[i], 0);
            chk("reset r_id", r_id[i], 0);
            chk("reset r_data", r_data[i], 0);
            chk("reset b_resp", b_resp[i], 0);
        end
        @(posedge aclk);
        #1 aresetn = 1'b1;

        // 16-beat burst write then read back on dcache id
        for (int k = 0; k < 16; k++) wdat[k] = 32'hA0 + k;
        wr(32'h100, 8'd15, 16, 4'hF);
        chk("burst bresp", last_bresp, 32'h0);
        rd(4'd1, 32'h100, 8'd15, 1'b0);
        chk("burst rd count u0", rq0.size(), 16);
        chk("burst rd count u1", rq1.size(), 16);
        for (int k = 0; k < 16 && k < rq0.size(); k++) chk($sformatf("burst rd u0 beat%0d", k), rq0[k], 32'hA0 + k);

        // byte strobes
        wdat[0] = 32'h11223344;
        wr(32'h40, 8'd0, 1, 4'hF);
        wdat[0] = 32'hAABBCCDD;
        wr(32'h40, 8'd0, 1, 4'b0101);
        rd(4'd0, 32'h40, 8'd0, 1'b0);
        chk("strobe u0", rq0.size() > 0 ? rq0[0] : 32'hX, 32'h11BB33DD);
        chk("strobe u1", rq1.size() > 0 ? rq1[0] : 32'hX, 32'h11BB33DD);

        // r_ready toggling against both latencies
        r_ready = 1'b0;
        rd(4'd2, 32'h100, 8'd15, 1'b1);
        chk("bp count u1", rq1.size(), 16);
        for (int k = 0; k < 16 && k < rq1.size(); k++) chk($sformatf("bp u1 beat%0d", k), rq1[k], 32'hA0 + k);

        // wrap at top of RAM with an overrun beat
        wdat[0] = 32'h00001111;
        wr(32'h4, 8'd0, 1, 4'hF);
        wdat[0] = 32'hDEAD0001; wdat[1] = 32'hDEAD0002; wdat[2] = 32'hDEAD0003;
        wr((DEPTH - 1) * 4, 8'd1, 3, 4'hF);
        chk("overrun bresp", last_bresp, 32'h2);
        rd(4'd0, (DEPTH - 1) * 4, 8'd2, 1'b0);
        chk("wrap count", rq0.size(), 3);
        if (rq0.size() == 3) begin
            chk("wrap top word", rq0[0], 32'hDEAD0001);
            chk("wrap word0", rq0[1], 32'hDEAD0002);
            chk("dropped beat word1", rq0[2], 32'h00001111);
        end

        // early w_last
        wr(32'h300, 8'd3, 2, 4'hF);
        chk("short burst bresp", last_bresp, 32'h2);

        // simultaneous AR and AW to the same word
        wait_idle(1'b0, 1'b0);
        rq0.delete();
        rq1.delete();
        ar_id = 4'd0; ar_addr = 32'h100; ar_len = 8'd0; ar_valid = 1'b1;
        aw_addr = 32'h100; aw_len = 8'd0; aw_valid = 1'b1;
        chk("conc ar_ready", ar_ready[0], 1);
        chk("conc aw_ready", aw_ready[0], 1);
        tick();
        ar_valid = 1'b0; aw_valid = 1'b0;
        chk("conc w_ready", w_ready[1], 1);
        wait_idle(1'b1, 1'b0);
        w_valid = 1'b1; w_data = 32'h00000055; w_strb = 4'hF; w_last = 1'b1;
        tick();
        w_valid = 1'b0; w_last = 1'b0;
        wait_idle(1'b0, 1'b0);
        chk("conc old data u0", rq0.size() > 0 ? rq0[0] : 32'hX, 32'hA0);
        chk("conc old data u1", rq1.size() > 0 ? rq1[0] : 32'hX, 32'hA0);
        chk("conc bresp", last_bresp, 32'h0);
        rd(4'd0, 32'h100, 8'd0, 1'b0);
        chk("conc new data", rq0.size() > 0 ? rq0[0] : 32'hX, 32'h55);

        // reset while a read is stalled and a write is half done
        wait_idle(1'b0, 1'b0);
        r_ready = 1'b0;
        ar_id = 4'd1; ar_addr = 32'h100; ar_len = 8'd15; ar_valid = 1'b1;
        aw_addr = 32'h200; aw_len = 8'd3; aw_valid = 1'b1;
        tick();
        ar_valid = 1'b0; aw_valid = 1'b0;
        w_valid = 1'b1; w_strb = 4'hF; w_data = 32'h0000200A;
        tick();
        w_data = 32'h0000200B;
        tick();
        w_valid = 1'b0;
        tick();
        chk("pre-reset r_valid u1", r_valid[1], 1);
        #2 aresetn = 1'b0;
        @(negedge aclk);
        for (int i = 0; i < 2; i++) begin
            chk("mid reset r_valid", r_valid[i], 0);
            chk("mid reset b_valid", b_valid[i], 0);
            chk("mid reset ar_ready", ar_ready[i], 1);
            chk("mid reset aw_ready", aw_ready[i], 1);
        end
        @(posedge aclk);
        #1 aresetn = 1'b1;
        r_ready = 1'b1;
        rd(4'd0, 32'h200, 8'd1, 1'b0);
        chk("partial write count", rq0.size(), 2);
        if (rq0.size() == 2) begin
            chk("partial write beat0", rq0[0], 32'h200A);
            chk("partial write beat1", rq0[1], 32'h200B);
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
